// File: rtl/switch_debouncer_pkg.sv
// Board-level constants for the CodeCracker I/O path, plus the helper that
// turns a debounce time into a clock-cycle count.
package codecracker_io_pkg;

    localparam int unsigned SW_WIDTH    = 10;
    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    function automatic int unsigned debounce_cycles(input int unsigned clkHz,
                                                    input int unsigned ms);
        return (clkHz / 1000) * ms;
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side bundle: raw pins in, clean levels and edge strobes out.
interface switch_debouncer_if
    import codecracker_io_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    modport master (
        output sw_raw,
        input  sw_out, rise, fall, changed
    );

    modport slave (
        input  sw_raw,
        output sw_out, rise, fall, changed
    );

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, persistence counter, stable level
// and one-cycle rise/fall strobes.
module switch_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw_i,
    output logic sw_out_o,
    output logic rise_o,
    output logic fall_o,
    output logic strobe_d_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sw_raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Any cycle where the synchronised level matches the stable one clears the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
                fall_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign sw_out_o   = stable_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign strobe_d_o = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the slide switches feeding the PIO and aggregates their edge
// strobes into a single registered 'changed' flag.
module switch_debouncer
    import codecracker_io_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = int'(debounce_cycles(CLK_HZ, DEBOUNCE_MS))
) (
    input  logic                clk,
    input  logic                reset,
    switch_debouncer_if.slave   sw
);

    logic [WIDTH-1:0] stable, riseV, fallV, strobeD;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .sw_raw_i  (sw.sw_raw[i]),
            .sw_out_o  (stable[i]),
            .rise_o    (riseV[i]),
            .fall_o    (fallV[i]),
            .strobe_d_o(strobeD[i])
        );
    end

    // Registered from the strobes' next-state so it lines up with rise/fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) changed_q <= 1'b0;
        else       changed_q <= |strobeD;
    end

    assign sw.sw_out  = stable;
    assign sw.rise    = riseV;
    assign sw.fall    = fallV;
    assign sw.changed = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES=4: vector
// table plus hand sequences for reset behaviour, checked through a scoreboard.
module tb_switch_debouncer;

    localparam int W = 10;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         changed;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t scoreQ[$];

    switch_debouncer_if #(.WIDTH(W)) sw();

    switch_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw.slave)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic [W-1:0] raw, input logic [W-1:0] out,
                          input logic [W-1:0] rise, input logic [W-1:0] fall,
                          input int n);
        vec_t v;
        v.raw = raw; v.out = out; v.rise = rise; v.fall = fall;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic pushExp(input logic [W-1:0] out, input logic [W-1:0] rise,
                           input logic [W-1:0] fall);
        exp_t e;
        e.out = out; e.rise = rise; e.fall = fall;
        e.changed = |(rise | fall);
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        checks++;
        if (scoreQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", name);
            return;
        end
        e = scoreQ.pop_front();
        if (sw.sw_out !== e.out || sw.rise !== e.rise || sw.fall !== e.fall ||
            sw.changed !== e.changed) begin
            errors++;
            $display("[TB] FAIL %s: got out=%h rise=%h fall=%h changed=%b, want out=%h rise=%h fall=%h changed=%b",
                     name, sw.sw_out, sw.rise, sw.fall, sw.changed,
                     e.out, e.rise, e.fall, e.changed);
        end
    endtask

    // Called at a falling edge: drives the input, checks after the next rising edge.
    task automatic applyStimulus(input string name, input logic [W-1:0] raw,
                                 input logic [W-1:0] out, input logic [W-1:0] rise,
                                 input logic [W-1:0] fall);
        sw.sw_raw = raw;
        pushExp(out, rise, fall);
        @(posedge clk);
        #1;
        checkOutput(name);
        @(negedge clk);
    endtask

    initial begin
        sw.sw_raw = '0;

        // Clean step, glitch, bounce and simultaneous-bit vectors.
        addVec(10'h000, 10'h000, 10'h000, 10'h000, 2);
        addVec(10'h001, 10'h000, 10'h000, 10'h000, 5);
        addVec(10'h001, 10'h001, 10'h001, 10'h000, 1);
        addVec(10'h001, 10'h001, 10'h000, 10'h000, 1);
        addVec(10'h000, 10'h001, 10'h000, 10'h000, 5);
        addVec(10'h000, 10'h000, 10'h000, 10'h001, 1);
        addVec(10'h000, 10'h000, 10'h000, 10'h000, 1);
        addVec(10'h008, 10'h000, 10'h000, 10'h000, 3);
        addVec(10'h000, 10'h000, 10'h000, 10'h000, 6);
        addVec(10'h020, 10'h000, 10'h000, 10'h000, 1);
        addVec(10'h000, 10'h000, 10'h000, 10'h000, 1);
        addVec(10'h020, 10'h000, 10'h000, 10'h000, 2);
        addVec(10'h000, 10'h000, 10'h000, 10'h000, 1);
        addVec(10'h020, 10'h000, 10'h000, 10'h000, 5);
        addVec(10'h020, 10'h020, 10'h020, 10'h000, 1);
        addVec(10'h020, 10'h020, 10'h000, 10'h000, 1);
        addVec(10'h000, 10'h020, 10'h000, 10'h000, 5);
        addVec(10'h000, 10'h000, 10'h000, 10'h020, 1);
        addVec(10'h000, 10'h000, 10'h000, 10'h000, 1);
        addVec(10'h3FF, 10'h000, 10'h000, 10'h000, 5);
        addVec(10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 1);
        addVec(10'h3FF, 10'h3FF, 10'h000, 10'h000, 1);
        addVec(10'h1FF, 10'h3FF, 10'h000, 10'h000, 5);
        addVec(10'h1FF, 10'h1FF, 10'h000, 10'h200, 1);
        addVec(10'h1FF, 10'h1FF, 10'h000, 10'h000, 1);
        addVec(10'h000, 10'h1FF, 10'h000, 10'h000, 5);
        addVec(10'h000, 10'h000, 10'h000, 10'h1FF, 1);
        addVec(10'h000, 10'h000, 10'h000, 10'h000, 1);

        @(negedge clk);
        for (int i = 0; i < 3; i++)
            applyStimulus("reset_hold", 10'h000, 10'h000, 10'h000, 10'h000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].raw, vecs[i].out,
                          vecs[i].rise, vecs[i].fall);

        // Bring outputs high, then reset between clock edges.
        for (int i = 0; i < 5; i++)
            applyStimulus("pre_async", 10'h3FF, 10'h000, 10'h000, 10'h000);
        applyStimulus("pre_async_rise", 10'h3FF, 10'h3FF, 10'h3FF, 10'h000);
        applyStimulus("pre_async_hold", 10'h3FF, 10'h3FF, 10'h000, 10'h000);
        #2;
        reset = 1'b1;
        #1;
        pushExp(10'h000, 10'h000, 10'h000);
        checkOutput("async_reset");
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            applyStimulus("async_reset_hold", 10'h3FF, 10'h000, 10'h000, 10'h000);
        reset = 1'b0;

        // Switches already on at reset release produce a rise after normal latency.
        for (int i = 0; i < 5; i++)
            applyStimulus("powerup_wait", 10'h3FF, 10'h000, 10'h000, 10'h000);
        applyStimulus("powerup_rise", 10'h3FF, 10'h3FF, 10'h3FF, 10'h000);
        for (int i = 0; i < 5; i++)
            applyStimulus("powerup_off", 10'h000, 10'h3FF, 10'h000, 10'h000);
        applyStimulus("powerup_fall", 10'h000, 10'h000, 10'h000, 10'h3FF);
        applyStimulus("idle", 10'h000, 10'h000, 10'h000, 10'h000);

        // Reset two cycles into a bit-2 count discards it.
        for (int i = 0; i < 2; i++)
            applyStimulus("midcount_pre", 10'h004, 10'h000, 10'h000, 10'h000);
        reset = 1'b1;
        #1;
        pushExp(10'h000, 10'h000, 10'h000);
        checkOutput("midcount_reset");
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            applyStimulus("midcount_hold", 10'h004, 10'h000, 10'h000, 10'h000);
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            applyStimulus("midcount_wait", 10'h004, 10'h000, 10'h000, 10'h000);
        applyStimulus("midcount_rise", 10'h004, 10'h004, 10'h004, 10'h000);
        applyStimulus("midcount_after", 10'h004, 10'h004, 10'h000, 10'h000);

        checks++;
        if (scoreQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d left, want 0", scoreQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
